fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO with ENA/RDY method handshakes on `enq`, `deq` and `first`. It replaces the fixed 32-bit stub FIFO, which has all RDY outputs tied low, with a working buffer of configurable width and depth. It adds occupancy and almost-full reporting. It sits between the request and indication paths of echo-style tests, and anywhere a user module needs decoupling between method callers.

## Interface
- WIDTH, 32, data width of `enq_v` and `first`.
- DEPTH, 4, number of entries; any integer ≥ 2, power of two not required.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which `afull` asserts; legal range 1..DEPTH.
- CNTW, $clog2(DEPTH+1), width of `count` (derived, not overridden).

- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- enq__ENA  in  1  enqueue request; honoured only when `enq__RDY`=1.
- enq_v  in  WIDTH  data to enqueue.
- enq__RDY  out  1  FIFO not full.
- deq__ENA  in  1  dequeue request; honoured only when `deq__RDY`=1.
- deq__RDY  out  1  FIFO not empty.
- first  out  WIDTH  head entry; 0 when empty.
- first__RDY  out  1  FIFO not empty; identical to `deq__RDY`.
- count  out  CNTW  current occupancy, 0..DEPTH.
- afull  out  1  `count` ≥ AFULL_LEVEL.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wp`, read pointer `rp`, occupancy counter `cnt`. Pointers range 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0, so no reliance on power-of-two overflow.
- Effective strobes:
  - enq_fire = enq__ENA & enq__RDY
  - deq_fire = deq__ENA & deq__RDY
  - An ENA while its RDY is low is ignored: no state change, no error.
- enq_fire: mem[wp] ← enq_v; wp advances.
- deq_fire: rp advances; the entry is not cleared.
- cnt update:
  - +1 on enq_fire only
  - −1 on deq_fire only
  - unchanged when both fire or neither fires
- enq__RDY = (cnt != DEPTH). deq__RDY = first__RDY = (cnt != 0).
- first = mem[rp] when cnt != 0, else all zeros. This is a combinational read of the array, with no output register.
- No bypass:
  - Empty FIFO: an enq is not visible on `first` in the same cycle, and deq cannot fire.
  - Full FIFO: enq__RDY is low even if deq fires in that cycle. No pipelined enq-while-full.
- Simultaneous enq_fire and deq_fire (0 < cnt < DEPTH): both pointers advance, cnt is unchanged, and the data ordering is preserved.

## Timing
- Reset (nRST=0, asynchronous): wp=rp=0, cnt=0 immediately, without waiting for CLK.
- Outputs during and after reset: enq__RDY=1, deq__RDY=0, first__RDY=0, first=0, count=0, afull=0.
  - Exception: AFULL_LEVEL cannot be 0, so afull=0 always holds at reset.
- Array contents are not reset. Their values are unobservable because `first` is masked while empty.
- Reset asserted mid-operation discards all entries. The first post-reset enq lands in mem[0].
- Deassertion of nRST is treated as synchronous to CLK by the surrounding design. The first fire can occur on the first CLK edge with nRST=1.
- Latency:
  - An enq at edge N gives first/first__RDY valid after edge N (usable in cycle N+1) when the FIFO was empty.
  - A deq at edge N presents the next entry after edge N.
- All RDY outputs, `count` and `afull` are pure functions of registered state. None depends combinationally on ENA inputs, so there are no ENA→RDY paths.
- Throughput: one enq and one deq per cycle sustained while 0 < cnt < DEPTH.

## Test plan
- Reset then idle: hold nRST=0 for 3 cycles, release -> enq__RDY=1, deq__RDY=0, first=0, count=0, afull=0.
- Fill and drain (WIDTH=32, DEPTH=4, AFULL_LEVEL=3):
  - Enq 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; afull rises after the 3rd enq; enq__RDY=0 after the 4th.
  - An extra enq of 0x55 while full is ignored.
  - Deq ×4 -> first shows 0x11,0x22,0x33,0x44 in order; count=0, first=0 at the end.
- Simultaneous enq/deq:
  - With count=2, assert both for 10 cycles with incrementing data -> count stays 2; dequeued order equals enqueue order.
  - Pointers wrap past DEPTH-1 at least twice.
- Non-power-of-two depth (DEPTH=3): enq/deq 7 items in a random-but-legal interleave -> ordering correct across wrap; count never exceeds 3.
- Deq while empty: pulse deq__ENA with count=0 -> no pointer change; a subsequent enq of 0xA5 appears on first next cycle with count=1.
- Asynchronous reset mid-stream: with count=3, drop nRST between clock edges -> count=0, deq__RDY=0 immediately. After release, enq 0x7 -> first=0x7 (the old entries are not visible).

Source files
------------

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with ENA/RDY method handshakes.
//
// Stores up to DEPTH entries of WIDTH bits in a register array. Pointers wrap
// explicitly at DEPTH-1, so any DEPTH >= 2 works (power of two not required).
// There is no bypass path: an entry written this cycle is first visible on
// `first` after the edge, and a full FIFO refuses enq even when deq fires.
//
// Parameters:
//   WIDTH        data width of enq_v and first
//   DEPTH        number of entries (>= 2)
//   AFULL_LEVEL  occupancy at or above which afull asserts (1..DEPTH)
//   CNTW         width of count (derived)
//
// Ports:
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   enq__ENA     enqueue request, honoured only while enq__RDY=1
//   enq_v        data to enqueue
//   enq__RDY     FIFO not full
//   deq__ENA     dequeue request, honoured only while deq__RDY=1
//   deq__RDY     FIFO not empty
//   first        head entry, all zeros while empty
//   first__RDY   FIFO not empty (same as deq__RDY)
//   count        current occupancy 0..DEPTH
//   afull        count >= AFULL_LEVEL
module fifo_param #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1,
  localparam int unsigned CNTW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             enq__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [WIDTH-1:0] first,
  output logic             first__RDY,
  output logic [CNTW-1:0]  count,
  output logic             afull
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTRW-1:0] LastPtr  = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FullCnt  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AfullCnt = CNTW'(AFULL_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wp;
  logic [PTRW-1:0]  r_rp;
  logic [CNTW-1:0]  r_cnt;

  logic             w_full;
  logic             w_not_empty;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [PTRW-1:0]  w_wp_next;
  logic [PTRW-1:0]  w_rp_next;

  // Status derives only from registered occupancy, so no ENA->RDY path exists.
  assign w_full      = (r_cnt == FullCnt);
  assign w_not_empty = (r_cnt != '0);

  assign w_enq_fire  = enq__ENA & ~w_full;
  assign w_deq_fire  = deq__ENA & w_not_empty;

  // Explicit wrap keeps non-power-of-two depths inside 0..DEPTH-1.
  assign w_wp_next   = (r_wp == LastPtr) ? '0 : r_wp + 1'b1;
  assign w_rp_next   = (r_rp == LastPtr) ? '0 : r_rp + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wp <= w_wp_next;
      end
      if (w_deq_fire) begin
        r_rp <= w_rp_next;
      end
      unique case ({w_enq_fire, w_deq_fire})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; stale contents are hidden because first is masked when empty.
  always_ff @(posedge CLK) begin
    if (w_enq_fire) begin
      r_mem[r_wp] <= enq_v;
    end
  end

  assign enq__RDY   = ~w_full;
  assign deq__RDY   = w_not_empty;
  assign first__RDY = w_not_empty;
  assign first      = w_not_empty ? r_mem[r_rp] : '0;
  assign count      = r_cnt;
  assign afull      = (r_cnt >= AfullCnt);

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a DEPTH=4 instance for fill/drain, concurrent
// enq/deq, empty-deq and async reset, and a DEPTH=3 instance for wrap ordering.
module tb_fifo_param;

  logic        clk;
  logic        nrst;

  // Instance A: WIDTH=32, DEPTH=4, AFULL_LEVEL=3
  logic        a_enq_ena;
  logic [31:0] a_enq_v;
  logic        a_enq_rdy;
  logic        a_deq_ena;
  logic        a_deq_rdy;
  logic [31:0] a_first;
  logic        a_first_rdy;
  logic [2:0]  a_count;
  logic        a_afull;

  // Instance B: WIDTH=32, DEPTH=3, AFULL_LEVEL=2 (default DEPTH-1)
  logic        b_enq_ena;
  logic [31:0] b_enq_v;
  logic        b_enq_rdy;
  logic        b_deq_ena;
  logic        b_deq_rdy;
  logic [31:0] b_first;
  logic        b_first_rdy;
  logic [1:0]  b_count;
  logic        b_afull;

  int unsigned n_checks;
  int unsigned n_errors;

  fifo_param #(
    .WIDTH       (32),
    .DEPTH       (4),
    .AFULL_LEVEL (3)
  ) u_dut_a (
    .CLK        (clk),
    .nRST       (nrst),
    .enq__ENA   (a_enq_ena),
    .enq_v      (a_enq_v),
    .enq__RDY   (a_enq_rdy),
    .deq__ENA   (a_deq_ena),
    .deq__RDY   (a_deq_rdy),
    .first      (a_first),
    .first__RDY (a_first_rdy),
    .count      (a_count),
    .afull      (a_afull)
  );

  fifo_param #(
    .WIDTH (32),
    .DEPTH (3)
  ) u_dut_b (
    .CLK        (clk),
    .nRST       (nrst),
    .enq__ENA   (b_enq_ena),
    .enq_v      (b_enq_v),
    .enq__RDY   (b_enq_rdy),
    .deq__ENA   (b_deq_ena),
    .deq__RDY   (b_deq_rdy),
    .first      (b_first),
    .first__RDY (b_first_rdy),
    .count      (b_count),
    .afull      (b_afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_enq_ena = 1'b0;
    a_deq_ena = 1'b0;
  endtask

  task automatic a_enq(input logic [31:0] v);
    a_enq_ena = 1'b1;
    a_enq_v   = v;
    a_deq_ena = 1'b0;
    tick();
    a_idle();
  endtask

  task automatic a_deq();
    a_enq_ena = 1'b0;
    a_deq_ena = 1'b1;
    tick();
    a_idle();
  endtask

  // DEPTH=3 interleave: bit1 = enq, bit0 = deq, one entry per cycle.
  logic [1:0] b_ops [12] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11,
                             2'b10, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00};
  int         b_q [$];

  initial begin
    int next_item;
    int deq_seen;
    logic do_enq;
    logic do_deq;

    n_checks  = 0;
    n_errors  = 0;
    nrst      = 1'b0;
    a_enq_ena = 1'b0;
    a_deq_ena = 1'b0;
    a_enq_v   = '0;
    b_enq_ena = 1'b0;
    b_deq_ena = 1'b0;
    b_enq_v   = '0;

    // Reset held for 3 cycles, then released between edges.
    repeat (3) tick();
    check("rst_enq_rdy", a_enq_rdy, 1);
    check("rst_deq_rdy", a_deq_rdy, 0);
    nrst = 1'b1;
    #2;
    check("idle_enq_rdy", a_enq_rdy, 1);
    check("idle_deq_rdy", a_deq_rdy, 0);
    check("idle_first_rdy", a_first_rdy, 0);
    check("idle_first", a_first, 0);
    check("idle_count", a_count, 0);
    check("idle_afull", a_afull, 0);

    // Fill: count 1..4, afull from 3, enq__RDY low at 4.
    a_enq(32'h11);
    check("fill1_count", a_count, 1);
    check("fill1_first", a_first, 32'h11);
    check("fill1_first_rdy", a_first_rdy, 1);
    check("fill1_afull", a_afull, 0);
    a_enq(32'h22);
    check("fill2_count", a_count, 2);
    check("fill2_afull", a_afull, 0);
    a_enq(32'h33);
    check("fill3_count", a_count, 3);
    check("fill3_afull", a_afull, 1);
    check("fill3_enq_rdy", a_enq_rdy, 1);
    a_enq(32'h44);
    check("fill4_count", a_count, 4);
    check("fill4_enq_rdy", a_enq_rdy, 0);
    check("fill4_first", a_first, 32'h11);

    // Enq while full is dropped.
    a_enq(32'h55);
    check("full_enq_count", a_count, 4);
    check("full_enq_first", a_first, 32'h11);

    // Drain in order.
    check("drain0_first", a_first, 32'h11);
    a_deq();
    check("drain1_first", a_first, 32'h22);
    check("drain1_count", a_count, 3);
    check("drain1_enq_rdy", a_enq_rdy, 1);
    a_deq();
    check("drain2_first", a_first, 32'h33);
    check("drain2_afull", a_afull, 0);
    a_deq();
    check("drain3_first", a_first, 32'h44);
    a_deq();
    check("drain4_count", a_count, 0);
    check("drain4_first", a_first, 0);
    check("drain4_deq_rdy", a_deq_rdy, 0);

    // Concurrent enq/deq at count=2 for 10 cycles; pointers wrap repeatedly.
    a_enq(32'h100);
    a_enq(32'h101);
    check("sim_pre_count", a_count, 2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("sim_first_%0d", k), a_first, 32'h100 + k);
      a_enq_ena = 1'b1;
      a_enq_v   = 32'h102 + k;
      a_deq_ena = 1'b1;
      tick();
      check($sformatf("sim_count_%0d", k), a_count, 2);
    end
    a_idle();
    check("sim_tail0", a_first, 32'h10A);
    a_deq();
    check("sim_tail1", a_first, 32'h10B);
    a_deq();
    check("sim_empty_count", a_count, 0);

    // Deq on empty must not move the read pointer.
    a_deq();
    check("empty_deq_count", a_count, 0);
    check("empty_deq_first", a_first, 0);
    a_enq(32'hA5);
    check("after_empty_first", a_first, 32'hA5);
    check("after_empty_count", a_count, 1);

    // Async reset between edges with count=3.
    a_enq(32'hB6);
    a_enq(32'hC7);
    check("pre_rst_count", a_count, 3);
    #3;
    nrst = 1'b0;
    #1;
    check("async_rst_count", a_count, 0);
    check("async_rst_deq_rdy", a_deq_rdy, 0);
    check("async_rst_first", a_first, 0);
    check("async_rst_enq_rdy", a_enq_rdy, 1);
    tick();
    nrst = 1'b1;
    #2;
    a_enq(32'h7);
    check("post_rst_first", a_first, 32'h7);
    check("post_rst_count", a_count, 1);

    // DEPTH=3 interleave against a queue model.
    next_item = 1;
    deq_seen  = 0;
    foreach (b_ops[i]) begin
      do_enq = b_ops[i][1] && (b_q.size() < 3) && (next_item <= 7);
      do_deq = b_ops[i][0] && (b_q.size() > 0);
      if (b_q.size() > 0) begin
        check($sformatf("b_first_%0d", i), b_first, b_q[0]);
      end else begin
        check($sformatf("b_first_empty_%0d", i), b_first, 0);
      end
      b_enq_ena = do_enq;
      b_enq_v   = next_item;
      b_deq_ena = do_deq;
      tick();
      if (do_deq) begin
        void'(b_q.pop_front());
        deq_seen++;
      end
      if (do_enq) begin
        b_q.push_back(next_item);
        next_item++;
      end
      check($sformatf("b_count_%0d", i), b_count, b_q.size());
      check($sformatf("b_afull_%0d", i), b_afull, (b_q.size() >= 2));
      check($sformatf("b_count_le3_%0d", i), (b_count <= 2'd3), 1);
    end
    b_enq_ena = 1'b0;
    b_deq_ena = 1'b0;
    check("b_all_deq", deq_seen, 7);
    check("b_end_deq_rdy", b_deq_rdy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
